seq_ripple_adder: RTL and testbench

- Multi-cycle, parametrised ripple-carry adder/subtractor.
- Adds WIDTH-bit operands one SLICE-bit chunk per clock, least-significant chunk first, holding the inter-slice carry in a register.
- Valid/ready handshake on both input and output. Successor to the fixed 5-bit combinational ripple adder; trades latency for a short critical path (SLICE full-adder stages).

---
 rtl/seq_ripple_adder_if.sv | 33 +++
 rtl/seq_ripple_adder.sv | 144 ++++++++++++++
 tb/tb_seq_ripple_adder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ripple_adder_if.sv
// Purpose: operand/result bundle for seq_ripple_adder.
// Latency: none; these are wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Ports (all sized by WIDTH):
//   master drives in_valid, a, b, carry_in, sub, out_ready and observes the rest.
//   slave  drives in_ready, sum, carry_out, overflow, out_valid, busy.
interface seq_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, sum, carry_out, overflow, out_valid, busy
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, sum, carry_out, overflow, out_valid, busy
    );
endinterface

// File: rtl/seq_ripple_adder.sv
// Purpose: multi-cycle ripple-carry adder/subtractor, SLICE bits per clock, LSB chunk first.
// Latency: operands accepted at edge E, out_valid first high after edge E+WIDTH/SLICE.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until return to IDLE.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of seq_ripple_adder_if (operands, result, handshakes, busy)
module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_ripple_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;     // already inverted for subtraction
    logic             carry_q;  // carry into the slice being processed
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             overflow_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic [SLICE:0]   c_chain;
    logic             last_slice;

    assign last_slice = (idx == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_slice)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Handshake flags decode straight from the registered state, so they are glitch-free.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

    // ---------------- datapath: select the current slice ----------------
    // Mux over constant part-selects keeps every index static.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_sl = op_a[i*SLICE +: SLICE];
                b_sl = op_b[i*SLICE +: SLICE];
            end
        end
    end

    // ---------------- datapath: SLICE-stage ripple chain ----------------
    always_comb begin
        s_sl       = '0;
        c_chain    = '0;
        c_chain[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            s_sl[i]      = a_sl[i] ^ b_sl[i] ^ c_chain[i];
            c_chain[i+1] = (a_sl[i] & b_sl[i]) | (c_chain[i] & (a_sl[i] ^ b_sl[i]));
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            carry_q     <= 1'b0;
            idx         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a    <= bus.a;
                        // a - b = a + ~b + 1; carry_in is ignored in subtract mode.
                        op_b    <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.carry_in;
                        sum_q   <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDXW'(i)) begin
                            sum_q[i*SLICE +: SLICE] <= s_sl;
                        end
                    end
                    carry_q <= c_chain[SLICE];
                    idx     <= idx + IDXW'(1);
                    if (last_slice) begin
                        idx         <= '0;
                        carry_out_q <= c_chain[SLICE];
                        // On the top slice, c_chain[SLICE-1] is the carry into bit WIDTH-1.
                        overflow_q  <= c_chain[SLICE] ^ c_chain[SLICE-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_ripple_adder.sv
module tb_seq_ripple_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_ripple_adder_if #(.WIDTH(16)) if16 ();
    seq_ripple_adder_if #(.WIDTH(5))  if5  ();

    seq_ripple_adder #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    seq_ripple_adder #(.WIDTH(5),  .SLICE(1)) u5  (.clk(clk), .rst_n(rst_n), .bus(if5));

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic; overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] mask;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] full;
        res_t        r;
        mask     = (32'h1 << w) - 32'h1;
        aa       = a & mask;
        bb       = (sub ? ~b : b) & mask;
        full     = {1'b0, aa} + {1'b0, bb} + 33'(sub | cin);
        r.sum    = full[31:0] & mask;
        r.cout   = full[w];
        r.ovf    = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    // Result monitor for the 16-bit instance: every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n && if16.out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at %0t", $time);
            end else begin
                check("mon_sum",      32'(if16.sum),       exp_q[0].sum);
                check("mon_cout",     32'(if16.carry_out), 32'(exp_q[0].cout));
                check("mon_ovf",      32'(if16.overflow),  32'(exp_q[0].ovf));
                check("mon_in_ready", 32'(if16.in_ready),  32'd0);
                if (if16.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called right after a clock edge (+1) with the DUT in IDLE.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input int hold,
                         output logic [15:0] r_sum, output logic r_cout, output logic r_ovf);
        int lat;
        check("idle_in_ready", 32'(if16.in_ready), 32'd1);
        check("idle_busy",     32'(if16.busy),     32'd0);
        if16.a         = a;
        if16.b         = b;
        if16.carry_in  = cin;
        if16.sub       = sub;
        if16.in_valid  = 1'b1;
        if16.out_ready = (hold == 0);
        exp_q.push_back(model(16, 32'(a), 32'(b), cin, sub));
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        check("run_busy",     32'(if16.busy),     32'd1);
        check("run_in_ready", 32'(if16.in_ready), 32'd0);
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            // Scramble inputs during RUN; the result must not depend on them.
            if16.a        = 16'($urandom);
            if16.b        = 16'($urandom);
            if16.carry_in = 1'($urandom);
            if16.sub      = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency16", 32'(lat), 32'd4);
        r_sum  = if16.sum;
        r_cout = if16.carry_out;
        r_ovf  = if16.overflow;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(if16.out_valid), 32'd1);
            check("hold_sum",       32'(if16.sum),       32'(r_sum));
            check("hold_cout",      32'(if16.carry_out), 32'(r_cout));
            check("hold_in_ready",  32'(if16.in_ready),  32'd0);
        end
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_out_valid", 32'(if16.out_valid), 32'd0);
        check("post_hs_in_ready",  32'(if16.in_ready),  32'd1);
        if16.out_ready = 1'($urandom);
    endtask

    task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic cin, input logic sub,
                        output logic [4:0] r_sum, output logic r_cout, output logic r_ovf);
        int   lat;
        res_t e;
        e = model(5, 32'(a), 32'(b), cin, sub);
        if5.a         = a;
        if5.b         = b;
        if5.carry_in  = cin;
        if5.sub       = sub;
        if5.in_valid  = 1'b1;
        if5.out_ready = 1'b1;
        @(posedge clk); #1;
        if5.in_valid = 1'b0;
        lat = 0;
        while (!if5.out_valid && lat < 20) begin
            if5.a = 5'($urandom);
            if5.b = 5'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency5", 32'(lat), 32'd5);
        check("sum5",  32'(if5.sum),       e.sum);
        check("cout5", 32'(if5.carry_out), 32'(e.cout));
        check("ovf5",  32'(if5.overflow),  32'(e.ovf));
        r_sum  = if5.sum;
        r_cout = if5.carry_out;
        r_ovf  = if5.overflow;
        @(posedge clk); #1;
        check("post_hs5_in_ready", 32'(if5.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] s16;
        logic [4:0]  s5;
        logic        co;
        logic        ov;

        rst_n = 1'b0;
        {if16.in_valid, if16.a, if16.b, if16.carry_in, if16.sub, if16.out_ready} = '0;
        {if5.in_valid,  if5.a,  if5.b,  if5.carry_in,  if5.sub,  if5.out_ready}  = '0;
        #1;
        check("rst_sum",       32'(if16.sum),       32'd0);
        check("rst_cout",      32'(if16.carry_out), 32'd0);
        check("rst_ovf",       32'(if16.overflow),  32'd0);
        check("rst_out_valid", 32'(if16.out_valid), 32'd0);
        check("rst_busy",      32'(if16.busy),      32'd0);
        check("rst_in_ready",  32'(if16.in_ready),  32'd1);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bit-serial 5-bit cases with hand-computed results.
        run5(5'b01100, 5'b10011, 1'b0, 1'b0, s5, co, ov);
        check("lit5_a_sum", 32'(s5), 32'b11111);
        check("lit5_a_cout", 32'(co), 32'd0);
        check("lit5_a_ovf", 32'(ov), 32'd0);
        run5(5'b01100, 5'b10011, 1'b1, 1'b0, s5, co, ov);
        check("lit5_b_sum", 32'(s5), 32'b00000);
        check("lit5_b_cout", 32'(co), 32'd1);
        run5(5'b01001, 5'b11011, 1'b1, 1'b0, s5, co, ov);
        check("lit5_c_sum", 32'(s5), 32'b00101);
        check("lit5_c_cout", 32'(co), 32'd1);
        for (int i = 0; i < 8; i++) begin
            run5(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), s5, co, ov);
        end

        // 16-bit directed cases.
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s16, co, ov);
        check("lit_ffff_sum", 32'(s16), 32'h0000);
        check("lit_ffff_cout", 32'(co), 32'd1);
        check("lit_ffff_ovf", 32'(ov), 32'd0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, s16, co, ov);
        check("lit_7fff_sum", 32'(s16), 32'h8000);
        check("lit_7fff_cout", 32'(co), 32'd0);
        check("lit_7fff_ovf", 32'(ov), 32'd1);
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, 0, s16, co, ov);
        check("lit_sub_sum", 32'(s16), 32'hFFFE);
        check("lit_sub_cout", 32'(co), 32'd0);
        check("lit_sub_ovf", 32'(ov), 32'd0);
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, 3, s16, co, ov);
        check("lit_sub2_sum", 32'(s16), 32'h7FFF);
        check("lit_sub2_ovf", 32'(ov), 32'd1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), s16, co, ov);
        end

        // Reset in the middle of RUN, after two slices.
        if16.a         = 16'h0C0C;
        if16.b         = 16'h1313;
        if16.carry_in  = 1'b0;
        if16.sub       = 1'b0;
        if16.in_valid  = 1'b1;
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial_sum", 32'(if16.sum), 32'h001F);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum",       32'(if16.sum),       32'd0);
        check("mid_rst_cout",      32'(if16.carry_out), 32'd0);
        check("mid_rst_ovf",       32'(if16.overflow),  32'd0);
        check("mid_rst_out_valid", 32'(if16.out_valid), 32'd0);
        check("mid_rst_busy",      32'(if16.busy),      32'd0);
        check("mid_rst_in_ready",  32'(if16.in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("aborted_no_valid", 32'(if16.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run16(16'h0C0C, 16'h1313, 1'b0, 1'b0, 1, s16, co, ov);
        check("lit_after_rst_sum", 32'(s16), 32'h1F1F);
        check("lit_after_rst_cout", 32'(co), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("results_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
